// File: rtl/psec5_pkg.sv
// Shared types and constants for the PSEC5 counter readout sequencer.
// Each channel's 56-bit counter word is read out as CNT_BYTES bytes.
package psec5_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    SHIFT,
    DRAIN,
    DONE
  } rdo_state_t;

  localparam int CNT_BYTES = 7;
  localparam int CNT_SEL_W = 3;
  localparam logic [CNT_SEL_W-1:0] LAST_SEL = CNT_SEL_W'(CNT_BYTES - 1);

endpackage

// File: rtl/psec5_ser_capture.sv
// One channel's byte deserialiser: LSB-first shift into an 8-bit capture register.
// cap_next exposes the value the register takes at the coming edge.
module psec5_ser_capture (
  input  logic       SPI_CLK,
  input  logic       RST,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       ser,
  output logic [7:0] cap,
  output logic [7:0] cap_next
);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cap_next = cap;
    if (clr) begin
      cap_next = '0;
    end else if (shift_en) begin
      cap_next = {ser, cap[7:1]};
    end
  end

  // NOTE: the capture register is plain flops, not a memory, so it is cleared on reset like all other state.
  always_ff @(posedge SPI_CLK) begin
    if (RST) begin
      cap <= '0;
    end else begin
      cap <= cap_next;
    end
  end

endmodule

// File: rtl/psec5_cnt_readout_seq.sv
// Counter readout sequencer: per byte index, pulses LOAD_CNT_SER, deserialises all channels in
// parallel, then streams the enabled channels' bytes over a valid/ready byte interface.
module psec5_cnt_readout_seq
  import psec5_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int SER_LAT = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 SPI_CLK,
  input  logic                 RST,
  input  logic                 READOUT_REQ,
  input  logic                 ABORT,
  input  logic [NUM_CH-1:0]    CH_MASK,
  input  logic [NUM_CH-1:0]    CNT_SER,
  output logic [CNT_SEL_W-1:0] SELECT_REG,
  output logic                 LOAD_CNT_SER,
  output logic [7:0]           BYTE_DATA,
  output logic [CH_W-1:0]      BYTE_CH,
  output logic [CNT_SEL_W-1:0] BYTE_IDX,
  output logic                 BYTE_VALID,
  input  logic                 BYTE_READY,
  output logic                 BUSY,
  output logic                 READOUT_DONE
);

  localparam int CNT_W = $clog2(SER_LAT + 8);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((SER_LAT >= 2) ? SER_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(7);

  rdo_state_t            state_q, state_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic [CNT_SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  valid_d;
  logic [7:0]            data_d;
  logic [CH_W-1:0]       ch_d;
  logic [CNT_SEL_W-1:0]  idx_d;

  logic [7:0]            cap      [NUM_CH];
  logic [7:0]            cap_next [NUM_CH];
  logic                  cap_clr, cap_shift;

  logic [CH_W-1:0]       first_ch, next_ch;
  logic                  has_next;

  assign cap_clr    = (state_q == LOAD);
  assign cap_shift  = (state_q == SHIFT);
  assign SELECT_REG = sel_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_cap
    psec5_ser_capture u_cap (
      .SPI_CLK  (SPI_CLK),
      .RST      (RST),
      .clr      (cap_clr),
      .shift_en (cap_shift),
      .ser      (CNT_SER[c]),
      .cap      (cap[c]),
      .cap_next (cap_next[c])
    );
  end

  // Lowest enabled channel, and the next enabled channel above the one currently presented.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (mask_q[c]) begin
        first_ch = CH_W'(c);
        if (c > int'(BYTE_CH)) begin
          next_ch  = CH_W'(c);
          has_next = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    valid_d = BYTE_VALID;
    data_d  = BYTE_DATA;
    ch_d    = BYTE_CH;
    idx_d   = BYTE_IDX;

    case (state_q)
      IDLE: begin
        if (READOUT_REQ) begin
          if (|CH_MASK) begin
            mask_d  = CH_MASK;
            sel_d   = '0;
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = (SER_LAT > 1) ? WAIT : SHIFT;
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          // The last bit is still in flight, so the first byte comes from cap_next.
          cnt_d   = '0;
          state_d = DRAIN;
          valid_d = 1'b1;
          ch_d    = first_ch;
          idx_d   = sel_q;
          data_d  = cap_next[first_ch];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (BYTE_VALID && BYTE_READY) begin
          if (has_next) begin
            ch_d   = next_ch;
            data_d = cap[next_ch];
          end else begin
            valid_d = 1'b0;
            if (sel_q == LAST_SEL) begin
              state_d = DONE;
            end else begin
              sel_d   = sel_q + 1'b1;
              state_d = LOAD;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort beats everything, including a request arriving in IDLE.
    if (ABORT) begin
      state_d = IDLE;
      mask_d  = mask_q;
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge SPI_CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      BYTE_VALID   <= 1'b0;
      BYTE_DATA    <= '0;
      BYTE_CH      <= '0;
      BYTE_IDX     <= '0;
      LOAD_CNT_SER <= 1'b0;
      BUSY         <= 1'b0;
      READOUT_DONE <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      BYTE_VALID   <= valid_d;
      BYTE_DATA    <= data_d;
      BYTE_CH      <= ch_d;
      BYTE_IDX     <= idx_d;
      LOAD_CNT_SER <= (state_d == LOAD);
      BUSY         <= (state_d inside {LOAD, WAIT, SHIFT, DRAIN});
      READOUT_DONE <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_psec5_cnt_readout_seq.sv
// Directed bench for psec5_cnt_readout_seq: channel serialiser model, byte scoreboard,
// latency, backpressure, abort and reset checks.
module tb_psec5_cnt_readout_seq;

  localparam int NUM_CH  = 8;
  localparam int SER_LAT = 2;

  logic       SPI_CLK = 1'b0;
  logic       RST = 1'b1;
  logic       READOUT_REQ = 1'b0;
  logic       ABORT = 1'b0;
  logic [7:0] CH_MASK = '0;
  logic [7:0] CNT_SER = '0;
  logic [2:0] SELECT_REG;
  logic       LOAD_CNT_SER;
  logic [7:0] BYTE_DATA;
  logic [2:0] BYTE_CH;
  logic [2:0] BYTE_IDX;
  logic       BYTE_VALID;
  logic       BYTE_READY = 1'b0;
  logic       BUSY;
  logic       READOUT_DONE;

  psec5_cnt_readout_seq #(.NUM_CH(NUM_CH), .SER_LAT(SER_LAT)) dut (
    .SPI_CLK      (SPI_CLK),
    .RST          (RST),
    .READOUT_REQ  (READOUT_REQ),
    .ABORT        (ABORT),
    .CH_MASK      (CH_MASK),
    .CNT_SER      (CNT_SER),
    .SELECT_REG   (SELECT_REG),
    .LOAD_CNT_SER (LOAD_CNT_SER),
    .BYTE_DATA    (BYTE_DATA),
    .BYTE_CH      (BYTE_CH),
    .BYTE_IDX     (BYTE_IDX),
    .BYTE_VALID   (BYTE_VALID),
    .BYTE_READY   (BYTE_READY),
    .BUSY         (BUSY),
    .READOUT_DONE (READOUT_DONE)
  );

  always #5 SPI_CLK = ~SPI_CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
  endtask

  // Channel counter words, layout {3'b0, trig_cnt, CE, CD, CC, CB, CA}.
  logic [55:0] words [NUM_CH];
  initial begin
    words[0] = {3'b000, 3'b101, 10'h000, 10'h000, 10'h000, 10'h000, 10'h155};
    words[1] = 56'h0A_1B2C_3D4E_5F60;
    words[2] = 56'h1F_EDCB_A987_6543;
    words[3] = 56'h00_1111_2222_3333;
    words[4] = 56'h1C_C0FF_EE00_1234;
    words[5] = 56'h12_3456_789A_BCDE;
    words[6] = 56'h03_0303_0303_0303;
    words[7] = 56'h05_A5A5_5A5A_0FF0;
  end

  // Channel model: bit k of the selected byte is sampled SER_LAT+k edges after LOAD is seen.
  int         ph = 100;
  logic [2:0] ch_sel = '0;
  always begin
    @(posedge SPI_CLK); #1;
    if (LOAD_CNT_SER) begin
      ph = 0;
      ch_sel = SELECT_REG;
    end else if (ph < 100) begin
      ph++;
    end
    for (int c = 0; c < NUM_CH; c++)
      CNT_SER[c] = (ph >= SER_LAT && ph < SER_LAT + 8) ? words[c][8*int'(ch_sel) + ph - SER_LAT] : 1'b0;
  end

  logic rnd_ready = 1'b0;
  logic ready_fix = 1'b0;
  always begin
    @(posedge SPI_CLK); #2;
    BYTE_READY = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // Monitor: samples pre-edge values at each rising edge.
  int          cyc = 0;
  int          load_cnt = 0, valid_cnt = 0, done_cnt = 0, sel7 = 0;
  logic [13:0] got [$];
  logic        stall_prev = 1'b0;
  logic [13:0] prev_b = '0;
  always @(posedge SPI_CLK) begin
    cyc++;
    if (!RST) begin
      if (LOAD_CNT_SER) load_cnt++;
      if (BYTE_VALID) valid_cnt++;
      if (READOUT_DONE) done_cnt++;
      if (SELECT_REG == 3'd7) sel7++;
      if (BYTE_VALID && stall_prev)
        check("stall_hold", 64'({BYTE_CH, BYTE_IDX, BYTE_DATA}), 64'(prev_b));
      if (BYTE_VALID && BYTE_READY) got.push_back({BYTE_CH, BYTE_IDX, BYTE_DATA});
    end
    stall_prev = !RST && !ABORT && BYTE_VALID && !BYTE_READY;
    prev_b     = {BYTE_CH, BYTE_IDX, BYTE_DATA};
  end

  task automatic tick();
    @(posedge SPI_CLK); #1;
  endtask

  int t0;

  task automatic start_req(input logic [7:0] m);
    CH_MASK     = m;
    READOUT_REQ = 1'b1;
    t0          = cyc;
    tick();
    READOUT_REQ = 1'b0;
    CH_MASK     = ~m;
  endtask

  task automatic wait_done(input string tag, input int budget,
                           output int ld_at, output int vd_at, output int dn_at);
    ld_at = -1; vd_at = -1; dn_at = -1;
    for (int i = 0; i < budget; i++) begin
      if (LOAD_CNT_SER && ld_at < 0) ld_at = cyc;
      if (BYTE_VALID && vd_at < 0) vd_at = cyc;
      if (READOUT_DONE) begin
        dn_at = cyc;
        break;
      end
      tick();
    end
    check({tag, "_done_reached"}, 64'(dn_at >= 0), 64'(1));
  endtask

  task automatic cmp_seq(input string tag, input int base, input logic [7:0] m);
    int n = 0;
    logic [13:0] e;
    for (int s = 0; s < 7; s++)
      for (int c = 0; c < NUM_CH; c++)
        if (m[c]) begin
          e = {3'(c), 3'(s), words[c][8*s +: 8]};
          if (base + n < got.size()) check(tag, 64'(got[base+n]), 64'(e));
          n++;
        end
    check({tag, "_len"}, 64'(got.size() - base), 64'(n));
  endtask

  initial begin
    int ld, vd, dn, base, lbase, vbase, dbase, s7base;
    bit found;

    repeat (3) tick();
    check("rst_valid", 64'(BYTE_VALID), 64'(0));
    check("rst_busy_done_load", 64'({BUSY, READOUT_DONE, LOAD_CNT_SER}), 64'(0));
    check("rst_byte", 64'({BYTE_CH, BYTE_IDX, BYTE_DATA, SELECT_REG}), 64'(0));
    RST = 1'b0;
    ready_fix = 1'b1;
    tick();

    // 1: single channel, known word, latency.
    base = got.size(); lbase = load_cnt;
    start_req(8'h01);
    wait_done("t1", 400, ld, vd, dn);
    check("t1_load_lat", 64'(ld), 64'(t0 + 1));
    check("t1_valid_lat", 64'(vd), 64'(t0 + 11));
    check("t1_done_lat", 64'(dn), 64'(t0 + 78));
    check("t1_busy_at_done", 64'(BUSY), 64'(0));
    check("t1_loads", 64'(load_cnt - lbase), 64'(7));
    check("t1_idx0", 64'(got[base][7:0]), 64'(8'h55));
    check("t1_idx1", 64'(got[base+1][7:0]), 64'(8'h01));
    check("t1_idx6", 64'(got[base+6][7:0]), 64'(8'h14));
    cmp_seq("t1_seq", base, 8'h01);
    tick();

    // 2: sparse mask, no bubbles, SELECT_REG never 7.
    base = got.size(); s7base = sel7;
    start_req(8'hA5);
    wait_done("t2", 600, ld, vd, dn);
    check("t2_done_lat", 64'(dn), 64'(t0 + 99));
    check("t2_sel7", 64'(sel7 - s7base), 64'(0));
    cmp_seq("t2_seq", base, 8'hA5);
    tick();

    // 3: empty mask completes immediately.
    base = got.size(); lbase = load_cnt; vbase = valid_cnt;
    start_req(8'h00);
    wait_done("t3", 20, ld, vd, dn);
    check("t3_done_lat", 64'(dn), 64'(t0 + 1));
    check("t3_no_load_seen", 64'(ld), 64'(-1));
    tick(); tick();
    check("t3_loads", 64'(load_cnt - lbase), 64'(0));
    check("t3_valids", 64'(valid_cnt - vbase), 64'(0));
    check("t3_bytes", 64'(got.size() - base), 64'(0));

    // 4: random backpressure.
    rnd_ready = 1'b1;
    base = got.size();
    start_req(8'hA5);
    wait_done("t4", 3000, ld, vd, dn);
    cmp_seq("t4_seq", base, 8'hA5);
    rnd_ready = 1'b0;
    ready_fix = 1'b1;
    tick();

    // 5: abort in SHIFT at sel 3, then a clean readout; abort beats a request in IDLE.
    dbase = done_cnt;
    start_req(8'hA5);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      if (LOAD_CNT_SER && SELECT_REG == 3'd3) begin found = 1; break; end
      tick();
    end
    check("t5_sel3_reached", 64'(found), 64'(1));
    repeat (3) tick();
    check("t5_busy_before", 64'(BUSY), 64'(1));
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("t5_abort_busy_valid_load", 64'({BUSY, BYTE_VALID, LOAD_CNT_SER}), 64'(0));
    repeat (5) tick();
    check("t5_no_done", 64'(done_cnt - dbase), 64'(0));
    lbase = load_cnt;
    ABORT = 1'b1;
    start_req(8'hA5);
    ABORT = 1'b0;
    check("t5_abort_req_busy", 64'(BUSY), 64'(0));
    tick();
    check("t5_abort_req_loads", 64'(load_cnt - lbase), 64'(0));
    base = got.size(); dbase = done_cnt;
    start_req(8'hA5);
    wait_done("t5", 600, ld, vd, dn);
    tick();
    check("t5_done_once", 64'(done_cnt - dbase), 64'(1));
    cmp_seq("t5_seq", base, 8'hA5);

    // 6: request while busy is ignored; reset mid-drain clears outputs.
    ready_fix = 1'b0;
    tick();
    base = got.size(); lbase = load_cnt;
    start_req(8'hA5);
    tick();
    check("t6_busy", 64'(BUSY), 64'(1));
    READOUT_REQ = 1'b1;
    CH_MASK = 8'hFF;
    tick();
    READOUT_REQ = 1'b0;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (BYTE_VALID) begin found = 1; break; end
      tick();
    end
    check("t6_valid_reached", 64'(found), 64'(1));
    check("t6_no_restart", 64'(load_cnt - lbase), 64'(1));
    check("t6_first_byte", 64'({BYTE_CH, BYTE_IDX, BYTE_DATA}), 64'({3'd0, 3'd0, words[0][7:0]}));
    ready_fix = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (got.size() - base >= 2) begin found = 1; break; end
    end
    ready_fix = 1'b0;
    check("t6_two_bytes", 64'(found), 64'(1));
    check("t6_second_ch", 64'(got[base+1][13:11]), 64'(2));
    tick();
    check("t6_stalled_valid", 64'(BYTE_VALID), 64'(1));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t6_rst_valid", 64'(BYTE_VALID), 64'(0));
    check("t6_rst_busy_done_load", 64'({BUSY, READOUT_DONE, LOAD_CNT_SER}), 64'(0));
    check("t6_rst_byte", 64'({BYTE_CH, BYTE_IDX, BYTE_DATA, SELECT_REG}), 64'(0));
    tick();
    check("t6_idle_after_rst", 64'(BUSY), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
